// File: rtl/program_loader_if.sv
// Stream + memory write bus between the boot stream source, the loader and the
// cpu external write ports. The loader sits on the slave side.
interface program_loader_if;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic [31:0] imem_addr;
   logic        imem_wen;
   logic [31:0] imem_wdata;
   logic [31:0] dmem_addr;
   logic        dmem_wen;
   logic [31:0] dmem_wdata;

   // Loader side: consumes the stream, drives the memory write ports.
   modport slave (
      input  s_valid, s_data,
      output s_ready,
      output imem_addr, imem_wen, imem_wdata,
      output dmem_addr, dmem_wen, dmem_wdata
   );

   // Environment side: produces the stream, observes the memory writes.
   modport master (
      output s_valid, s_data,
      input  s_ready,
      input  imem_addr, imem_wen, imem_wdata,
      input  dmem_addr, dmem_wen, dmem_wdata
   );
endinterface

// File: rtl/program_loader.sv
// Boot loader: takes a header/payload/trailer word stream, writes imem and
// dmem through the cpu external write ports, verifies the additive checksum
// and then owns the cpu enable until a stop is requested.
module program_loader #(
   parameter int unsigned IMEM_WORDS = 512,
   parameter int unsigned DMEM_WORDS = 1024,
   parameter int unsigned ADDR_STEP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                stop_i,
   program_loader_if.slave     bus,
   output logic                cpu_enable_o,
   output logic                busy_o,
   output logic                error_o,
   output logic [1:0]          err_code_o
);

   localparam logic [31:0] IMEM_LIM = 32'(IMEM_WORDS);
   localparam logic [31:0] DMEM_LIM = 32'(DMEM_WORDS);
   localparam logic [31:0] STEP     = 32'(ADDR_STEP);

   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_LOAD_I, S_LOAD_D, S_CHECK, S_RUN, S_ERROR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] csum_q, csum_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] ni_q, ni_d;
   logic [15:0] nd_q, nd_d;
   logic [1:0]  err_q, err_d;

   logic        s_ready_q;
   logic        imem_wen_q, imem_wen_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic [31:0] imem_wdata_q, imem_wdata_d;
   logic        dmem_wen_q, dmem_wen_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic        cpu_enable_q, busy_q, error_q;

   logic        accept;
   logic        last_i, last_d;

   // s_ready_q is registered from the next state, so it always matches state_q.
   assign accept = bus.s_valid & s_ready_q;
   assign last_i = ({1'b0, cnt_q} + 17'd1) == {1'b0, ni_q};
   assign last_d = ({1'b0, cnt_q} + 17'd1) == {1'b0, nd_q};

   // Next-state and datapath decode for the load sequence.
   always_comb begin
      state_d      = state_q;
      csum_d       = csum_q;
      cnt_d        = cnt_q;
      ni_d         = ni_q;
      nd_d         = nd_q;
      err_d        = err_q;
      imem_wen_d   = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      dmem_wen_d   = 1'b0;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      case (state_q)
         S_IDLE, S_ERROR: begin
            if (start_i) begin
               state_d = S_HEADER;
               csum_d  = '0;
               cnt_d   = '0;
               err_d   = 2'b00;
            end
         end
         S_HEADER: begin
            if (accept) begin
               csum_d = csum_q + bus.s_data;
               ni_d   = bus.s_data[15:0];
               nd_d   = bus.s_data[31:16];
               if ({16'd0, bus.s_data[15:0]} > IMEM_LIM ||
                   {16'd0, bus.s_data[31:16]} > DMEM_LIM) begin
                  state_d = S_ERROR;
                  err_d   = 2'b01;
               end else if (bus.s_data[15:0] != 16'd0) begin
                  state_d = S_LOAD_I;
               end else if (bus.s_data[31:16] != 16'd0) begin
                  state_d = S_LOAD_D;
               end else begin
                  state_d = S_CHECK;
               end
            end
         end
         S_LOAD_I: begin
            if (accept) begin
               csum_d       = csum_q + bus.s_data;
               imem_wen_d   = 1'b1;
               imem_addr_d  = {16'd0, cnt_q} * STEP;
               imem_wdata_d = bus.s_data;
               if (last_i) begin
                  cnt_d   = '0;
                  state_d = (nd_q != 16'd0) ? S_LOAD_D : S_CHECK;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_LOAD_D: begin
            if (accept) begin
               csum_d       = csum_q + bus.s_data;
               dmem_wen_d   = 1'b1;
               dmem_addr_d  = {16'd0, cnt_q} * STEP;
               dmem_wdata_d = bus.s_data;
               if (last_d) begin
                  cnt_d   = '0;
                  state_d = S_CHECK;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_CHECK: begin
            if (accept) begin
               if (bus.s_data == csum_q) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_ERROR;
                  err_d   = 2'b10;
               end
            end
         end
         S_RUN: begin
            if (stop_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs; status outputs follow the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         csum_q       <= '0;
         cnt_q        <= '0;
         ni_q         <= '0;
         nd_q         <= '0;
         err_q        <= 2'b00;
         s_ready_q    <= 1'b0;
         imem_wen_q   <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         dmem_wen_q   <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         cpu_enable_q <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         csum_q       <= csum_d;
         cnt_q        <= cnt_d;
         ni_q         <= ni_d;
         nd_q         <= nd_d;
         err_q        <= err_d;
         imem_wen_q   <= imem_wen_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         dmem_wen_q   <= dmem_wen_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         busy_q       <= (state_d == S_HEADER) || (state_d == S_LOAD_I) ||
                         (state_d == S_LOAD_D) || (state_d == S_CHECK);
         s_ready_q    <= (state_d == S_HEADER) || (state_d == S_LOAD_I) ||
                         (state_d == S_LOAD_D) || (state_d == S_CHECK);
         cpu_enable_q <= (state_d == S_RUN);
         error_q      <= (state_d == S_ERROR);
      end
   end

   assign bus.s_ready    = s_ready_q;
   assign bus.imem_wen   = imem_wen_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign bus.dmem_wen   = dmem_wen_q;
   assign bus.dmem_addr  = dmem_addr_q;
   assign bus.dmem_wdata = dmem_wdata_q;
   assign cpu_enable_o   = cpu_enable_q;
   assign busy_o         = busy_q;
   assign error_o        = error_q;
   assign err_code_o     = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: stimulus pushes expected memory writes
// into queues, a negedge monitor pops and compares every write pulse.
module tb_program_loader;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       cpu_enable, busy, error;
   logic [1:0] err_code;
   bit         mon_en = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [63:0] imem_q[$];
   logic [63:0] dmem_q[$];

   logic [31:0] iw [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
   logic [31:0] dw [2] = '{32'h4444_4444, 32'h5555_5555};
   localparam logic [31:0] HDR = 32'h0002_0003;
   localparam logic [31:0] SUM = 32'h0002_0002; // hand sum, wraps past 2^32

   program_loader_if bus();

   program_loader #(.IMEM_WORDS(512), .DMEM_WORDS(1024), .ADDR_STEP(4)) dut (
      .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .bus(bus.slave),
      .cpu_enable_o(cpu_enable), .busy_o(busy), .error_o(error), .err_code_o(err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Write scoreboard and s_ready-while-busy monitor.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.imem_wen === 1'b1) begin
            if (imem_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL imem_unexpected_write actual=%h required=none", bus.imem_addr);
            end else begin
               logic [63:0] e;
               e = imem_q.pop_front();
               chk("imem_addr", bus.imem_addr, e[63:32]);
               chk("imem_wdata", bus.imem_wdata, e[31:0]);
            end
         end
         if (bus.dmem_wen === 1'b1) begin
            if (dmem_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL dmem_unexpected_write actual=%h required=none", bus.dmem_addr);
            end else begin
               logic [63:0] e;
               e = dmem_q.pop_front();
               chk("dmem_addr", bus.dmem_addr, e[63:32]);
               chk("dmem_wdata", bus.dmem_wdata, e[31:0]);
            end
         end
         if (busy === 1'b1) chk("s_ready_in_busy", {31'd0, bus.s_ready}, 32'd1);
         if (cpu_enable === 1'b1) chk("enable_only_when_idle_bus", {31'd0, busy}, 32'd0);
      end
   end

   // Present one word and wait (bounded) for its handshake; called at a negedge.
   task automatic send(input logic [31:0] d, input bit gap);
      int n = 0;
      if (gap) begin
         while ($urandom_range(0, 1) == 1) begin
            bus.s_valid = 1'b0;
            @(negedge clk);
         end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      while (bus.s_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL handshake_timeout actual=no_ready required=ready data=%h", d);
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic basic_stream(input bit gap, input logic [31:0] trl);
      send(HDR, gap);
      for (int i = 0; i < 3; i++) begin
         imem_q.push_back({32'(i * 4), iw[i]});
         send(iw[i], gap);
      end
      for (int i = 0; i < 2; i++) begin
         dmem_q.push_back({32'(i * 4), dw[i]});
         send(dw[i], gap);
      end
      send(trl, gap);
   endtask

   task automatic drain_check(input string tag);
      repeat (3) @(negedge clk);
      chk({tag, "_imem_pending"}, 32'(imem_q.size()), 32'd0);
      chk({tag, "_dmem_pending"}, 32'(dmem_q.size()), 32'd0);
   endtask

   task automatic stop_run(input string tag);
      chk({tag, "_en_before_stop"}, {31'd0, cpu_enable}, 32'd1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk({tag, "_en_after_stop"}, {31'd0, cpu_enable}, 32'd0);
      chk({tag, "_busy_after_stop"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (3) @(negedge clk);
      // Reset state
      chk("rst_enable", {31'd0, cpu_enable}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_err_code", {30'd0, err_code}, 32'd0);
      chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
      chk("rst_wen", {30'd0, bus.imem_wen, bus.dmem_wen}, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Basic load
      do_start();
      chk("hdr_busy", {31'd0, busy}, 32'd1);
      basic_stream(1'b0, SUM);
      @(negedge clk);
      chk("basic_enable", {31'd0, cpu_enable}, 32'd1);
      chk("basic_error", {31'd0, error}, 32'd0);
      drain_check("basic");
      // start in RUN is ignored
      do_start();
      chk("run_start_ignored_en", {31'd0, cpu_enable}, 32'd1);
      chk("run_start_ignored_busy", {31'd0, busy}, 32'd0);
      stop_run("basic");

      // Bad trailer, then recovery
      do_start();
      basic_stream(1'b0, SUM + 32'd1);
      @(negedge clk);
      chk("bad_error", {31'd0, error}, 32'd1);
      chk("bad_err_code", {30'd0, err_code}, 32'd2);
      chk("bad_enable", {31'd0, cpu_enable}, 32'd0);
      chk("bad_s_ready", {31'd0, bus.s_ready}, 32'd0);
      drain_check("bad");
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_in_error_ignored", {31'd0, error}, 32'd1);
      do_start();
      chk("restart_err_cleared", {30'd0, err_code}, 32'd0);
      basic_stream(1'b0, SUM);
      @(negedge clk);
      chk("recover_enable", {31'd0, cpu_enable}, 32'd1);
      drain_check("recover");
      stop_run("recover");

      // Overflow: N_I = 513
      do_start();
      send(32'h0000_0201, 1'b0);
      @(negedge clk);
      chk("ovf_i_error", {31'd0, error}, 32'd1);
      chk("ovf_i_err_code", {30'd0, err_code}, 32'd1);
      drain_check("ovf_i");
      // Overflow: N_D = 1025
      do_start();
      send(32'h0401_0000, 1'b0);
      @(negedge clk);
      chk("ovf_d_err_code", {30'd0, err_code}, 32'd1);
      chk("ovf_d_enable", {31'd0, cpu_enable}, 32'd0);

      // Empty program
      do_start();
      send(32'h0000_0000, 1'b0);
      chk("empty_in_check_busy", {31'd0, busy}, 32'd1);
      send(32'h0000_0000, 1'b0);
      @(negedge clk);
      chk("empty_enable", {31'd0, cpu_enable}, 32'd1);
      chk("empty_error", {31'd0, error}, 32'd0);
      drain_check("empty");
      stop_run("empty");

      // Gapped stream: same writes as the gap-free run
      do_start();
      basic_stream(1'b1, SUM);
      @(negedge clk);
      chk("gap_enable", {31'd0, cpu_enable}, 32'd1);
      drain_check("gap");
      stop_run("gap");

      // rst during the 2nd imem word
      do_start();
      send(32'h0000_0003, 1'b0);
      imem_q.push_back({32'd0, 32'hA5A5_0001});
      send(32'hA5A5_0001, 1'b0);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hA5A5_0002;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_s_ready", {31'd0, bus.s_ready}, 32'd0);
      chk("midrst_wen", {30'd0, bus.imem_wen, bus.dmem_wen}, 32'd0);
      chk("midrst_imem_addr", bus.imem_addr, 32'd0);
      chk("midrst_enable_err", {29'd0, cpu_enable, err_code}, 32'd0);
      bus.s_valid = 1'b0;
      rst = 1'b0;
      drain_check("midrst");
      chk("midrst_idle_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
